zbt_to_vga: RTL and testbench



---
 rtl/zbt_video_pkg.sv | 32 +++
 rtl/zbt_to_vga_forecast.sv | 35 +++
 rtl/zbt_to_vga.sv | 102 ++++++++++
 tb/tb_zbt_to_vga.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/zbt_video_pkg.sv
// Shared definitions for the ZBT frame store: field widths, pixel/word types and
// the address encoding used by both the writer and the reader.
package zbt_video_pkg;

   localparam int H_TOTAL_DEF = 1344;
   localparam int V_TOTAL_DEF = 806;

   localparam int ADDR_Y_W  = 9;
   localparam int ADDR_EO_W = 1;
   localparam int ADDR_X_W  = 9;
   localparam int ADDR_W    = ADDR_Y_W + ADDR_EO_W + ADDR_X_W;

   localparam int PIX_W  = 18;
   localparam int WORD_W = 2 * PIX_W;

   typedef logic [ADDR_W-1:0] vram_addr_t;
   typedef logic [PIX_W-1:0]  pixel_t;
   typedef logic [WORD_W-1:0] vram_word_t;

   // Travels alongside an outstanding read so the returning word can be interpreted.
   typedef struct packed {
      logic in_img;
      logic odd;
   } fetch_tag_t;

   function automatic vram_addr_t pack_vram_addr(input logic [ADDR_Y_W-1:0]  y,
                                                 input logic [ADDR_EO_W-1:0] eo,
                                                 input logic [ADDR_X_W-1:0]  x);
      return {y, eo, x};
   endfunction

endpackage

// File: rtl/zbt_to_vga_forecast.sv
// Combinational look-ahead of the raster position: where the raster will be
// FORECAST clocks from now, and whether that position lies inside the image.
module raster_forecast
   import zbt_video_pkg::*;
#(
   parameter int H_TOTAL  = H_TOTAL_DEF,
   parameter int V_TOTAL  = V_TOTAL_DEF,
   parameter int IMG_W    = 1024,
   parameter int IMG_H    = 768,
   parameter int FORECAST = 3
) (
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic [9:0]  hf,
   output logic [9:0]  vf,
   output logic        in_img
);

   logic [11:0] hs;
   logic [11:0] hf_full;

   always_comb begin
      hs      = {1'b0, hcount} + 12'(FORECAST);
      hf_full = hs;
      vf      = vcount;
      if (hs >= 12'(H_TOTAL)) begin
         hf_full = hs - 12'(H_TOTAL);
         vf      = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
      end
      // Only the low bits are needed for addressing; in_img sees the full range.
      hf     = hf_full[9:0];
      in_img = (hf_full < 12'(IMG_W)) && ({2'b00, vf} < 12'(IMG_H));
   end

endmodule

// File: rtl/zbt_to_vga.sv
// Reads two-pixel words from the ZBT frame store ahead of the XVGA raster and
// serialises them into one pixel per clock, black outside the stored image.
module zbt_to_vga
   import zbt_video_pkg::*;
#(
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int IMG_W       = 1024,
   parameter int IMG_H       = 768,
   parameter int ZBT_LATENCY = 2,
   parameter int FORECAST    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   output logic [ADDR_W-1:0] vram_addr,
   input  logic [WORD_W-1:0] vram_read_data,
   output logic [PIX_W-1:0]  vr_pixel,
   output logic              pixel_valid
);

   if (IMG_W % 2 != 0) begin : g_bad_width
      $error("zbt_to_vga: IMG_W must be even");
   end
   if (FORECAST != ZBT_LATENCY + 1) begin : g_bad_forecast
      $error("zbt_to_vga: FORECAST must equal ZBT_LATENCY+1");
   end

   logic [9:0] hf;
   logic [9:0] vf;
   logic       in_img;

   raster_forecast #(
      .H_TOTAL  (H_TOTAL),
      .V_TOTAL  (V_TOTAL),
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .FORECAST (FORECAST)
   ) u_forecast (
      .hcount (hcount),
      .vcount (vcount),
      .hf     (hf),
      .vf     (vf),
      .in_img (in_img)
   );

   vram_addr_t addr_reg;
   vram_word_t word_reg;
   logic       wvalid_reg;
   pixel_t     pixel_reg;
   logic       pixel_valid_reg;

   // Stage 0 is captured with the address, stage ZBT_LATENCY-1 lines up with
   // the returning data, and the extra last stage selects the half-word.
   fetch_tag_t tag_reg [ZBT_LATENCY+1];
   fetch_tag_t tag_aligned;
   fetch_tag_t tag_sel;

   assign tag_aligned = tag_reg[ZBT_LATENCY-1];
   assign tag_sel     = tag_reg[ZBT_LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg <= '0;
         for (int i = 0; i <= ZBT_LATENCY; i++) tag_reg[i] <= '0;
      end else begin
         addr_reg   <= in_img ? pack_vram_addr(vf[9:1], vf[0], hf[9:1]) : '0;
         tag_reg[0] <= '{in_img: in_img, odd: hf[0]};
         for (int i = 1; i <= ZBT_LATENCY; i++) tag_reg[i] <= tag_reg[i-1];
      end
   end

   // An even-x tag loads a fresh word; the following odd-x tag reuses it.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_reg   <= '0;
         wvalid_reg <= 1'b0;
      end else if (tag_aligned.in_img && !tag_aligned.odd) begin
         word_reg   <= vram_read_data;
         wvalid_reg <= 1'b1;
      end else if (!tag_aligned.in_img) begin
         wvalid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_reg       <= '0;
         pixel_valid_reg <= 1'b0;
      end else begin
         pixel_reg       <= !wvalid_reg ? '0
                          : (tag_sel.odd ? word_reg[PIX_W-1:0] : word_reg[WORD_W-1:PIX_W]);
         pixel_valid_reg <= wvalid_reg;
      end
   end

   assign vram_addr   = addr_reg;
   assign vr_pixel    = pixel_reg;
   assign pixel_valid = pixel_valid_reg;

endmodule

// File: tb/tb_zbt_to_vga.sv
// Drives raster segments into zbt_to_vga against a randomly filled ZBT model and
// compares address and pixel outputs with a position-based reference model.
module tb_zbt_to_vga;

   localparam int HT = 1344;
   localparam int VT = 806;
   localparam int IW = 1024;
   localparam int IH = 768;
   localparam int FC = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [18:0] vram_addr;
   logic [35:0] vram_read_data = '0;
   logic [17:0] vr_pixel;
   logic        pixel_valid;

   always #5 clk = ~clk;

   zbt_to_vga dut (
      .clk            (clk),
      .reset          (reset),
      .hcount         (hcount),
      .vcount         (vcount),
      .vram_addr      (vram_addr),
      .vram_read_data (vram_read_data),
      .vr_pixel       (vr_pixel),
      .pixel_valid    (pixel_valid)
   );

   // Frame store; together with the DUT's own address flop this gives two clocks
   // from forecast address to data.
   logic [35:0] zbt_mem [0:524287];
   always @(posedge clk) vram_read_data <= zbt_mem[vram_addr];

   int checks = 0;
   int errors = 0;
   int cur_h;
   int cur_v;
   int warm;
   int since_rel;

   task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (h=%0d v=%0d)", tag, got, exp, cur_h, cur_v);
      end
   endtask

   // Address the reader should issue while the raster sits at (h, v).
   function automatic logic [18:0] exp_addr(input int h, input int v);
      int lin;
      int fh;
      int fv;
      lin = (v * HT + h + FC) % (HT * VT);
      fh  = lin % HT;
      fv  = lin / HT;
      if (fh < IW && fv < IH) return 19'((fv / 2) * 1024 + (fv % 2) * 512 + fh / 2);
      return 19'd0;
   endfunction

   function automatic logic [17:0] exp_pix(input int h, input int v);
      logic [35:0] w;
      if (h >= IW || v >= IH) return 18'd0;
      w = zbt_mem[(v / 2) * 1024 + (v % 2) * 512 + h / 2];
      return (h % 2 == 0) ? w[35:18] : w[17:0];
   endfunction

   task automatic set_pos(input int h, input int v);
      cur_h  = h;
      cur_v  = v;
      hcount = 11'(h);
      vcount = 10'(v);
   endtask

   // One raster clock: outputs seen after the edge belong to column cur_h.
   task automatic tick();
      @(posedge clk);
      #1;
      if (reset) begin
         check_val("rst_addr", 36'(vram_addr), 36'd0);
         check_val("rst_valid", 36'(pixel_valid), 36'd0);
         check_val("rst_pixel", 36'(vr_pixel), 36'd0);
      end else begin
         check_val("addr", 36'(vram_addr), 36'(exp_addr(cur_h, cur_v)));
         if (since_rel < FC) check_val("post_rst_valid", 36'(pixel_valid), 36'd0);
         since_rel++;
         if (warm >= 5) begin
            check_val("valid", 36'(pixel_valid), 36'(cur_h < IW && cur_v < IH));
            check_val("pixel", 36'(vr_pixel), 36'(exp_pix(cur_h, cur_v)));
            if (cur_v == 11 && cur_h == 0) check_val("x0_even_half", 36'(vr_pixel), 36'h3AAAA);
            if (cur_v == 11 && cur_h == 1) check_val("x1_odd_half", 36'(vr_pixel), 36'h15555);
            if (cur_v == 11 && cur_h == 120) check_val("mid_line_valid", 36'(pixel_valid), 36'd1);
         end
         if (cur_v == 11 && cur_h == 1341)
            check_val("next_line_addr", 36'(vram_addr), 36'({9'd6, 1'b0, 9'd0}));
         if (cur_v == 11 && cur_h == 1021)
            check_val("right_edge_addr", 36'(vram_addr), 36'd0);
         if (cur_v == 805 && cur_h == 1342)
            check_val("frame_wrap_addr", 36'(vram_addr), 36'd0);
      end
      warm++;
      if (cur_h == HT - 1) set_pos(0, (cur_v == VT - 1) ? 0 : cur_v + 1);
      else set_pos(cur_h + 1, cur_v);
   endtask

   task automatic run_seg(input int h, input int v, input int n);
      $display("segment start h=%0d v=%0d cycles=%0d", h, v, n);
      set_pos(h, v);
      warm = 0;
      repeat (n) tick();
   endtask

   initial begin
      logic [63:0] r;
      int y;
      for (int i = 0; i < 524288; i++) begin
         r = {$urandom, $urandom};
         zbt_mem[i] = r[35:0];
      end
      zbt_mem[{9'd5, 1'b1, 9'd0}] = {18'h3AAAA, 18'h15555};

      // Reset held 5 clocks mid-line, released at hcount=100 on line 10.
      reset     = 1'b1;
      since_rel = 0;
      warm      = 0;
      set_pos(95, 10);
      $display("segment reset h=95 v=10 cycles=5");
      repeat (5) tick();
      reset     = 1'b0;
      warm      = 0;
      since_rel = 0;
      $display("segment release h=%0d v=%0d cycles=%0d", cur_h, cur_v, 2 * HT + 200);
      repeat (2 * HT + 200) tick();

      run_seg(1300, 804, HT + 200);
      run_seg(1000, 766, 4 * HT);
      for (int k = 0; k < 24; k++) begin
         y = int'($urandom_range(0, IH - 1));
         run_seg(1200, (y == 0) ? VT - 1 : y - 1, HT + 200);
      end
      run_seg(int'($urandom_range(0, HT - 1)), int'($urandom_range(0, VT - 1)), 3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
